// File: rtl/jk_bank_pkg.sv
// Shared mode encodings for the JK register bank.
package jk_bank_pkg;

    typedef logic [1:0] jk_mode_t;

    localparam jk_mode_t MODE_JK = 2'b00;
    localparam jk_mode_t MODE_D  = 2'b01;
    localparam jk_mode_t MODE_UP = 2'b10;
    localparam jk_mode_t MODE_DN = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with clock enable, synchronous load and async preset-to-value reset.
module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic en,
    input  logic load,
    input  logic d,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    // Hold when disabled; load overrides the JK table.
    always_comb begin
        q_d = q_q;
        if (en) begin
            if (load) begin
                q_d = d;
            end else begin
                case ({j, k})
                    2'b01:   q_d = 1'b0;
                    2'b10:   q_d = 1'b1;
                    2'b11:   q_d = ~q_q;
                    default: q_d = q_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= rst_val;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_register_bank.sv
// Bank of JK cells with D capture and up/down counting built from JK toggle terms.
// Optional sticky per-bit change flags when JK_BANK_CHANGE_FLAG_EN is defined.
module jk_register_bank
    import jk_bank_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
`ifdef JK_BANK_CHANGE_FLAG_EN
    input  logic             clr_flags,
    output logic [WIDTH-1:0] changed,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar,
    output logic             tc
);

    logic [WIDTH-1:0] ones_below;
    logic [WIDTH-1:0] zeros_below;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;

    // Carry/borrow chain: bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        ones_below     = '0;
        zeros_below    = '0;
        ones_below[0]  = 1'b1;
        zeros_below[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            ones_below[i]  = ones_below[i-1] & Q[i-1];
            zeros_below[i] = zeros_below[i-1] & ~Q[i-1];
        end
    end

    assign toggle = (jk_mode_t'(mode) == MODE_DN) ? zeros_below : ones_below;

    always_comb begin
        cell_j = J;
        cell_k = K;
        case (jk_mode_t'(mode))
            MODE_D: begin
                cell_j = d;
                cell_k = ~d;
            end
            MODE_UP, MODE_DN: begin
                cell_j = toggle;
                cell_k = toggle;
            end
            default: begin
                cell_j = J;
                cell_k = K;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk     (clk),
            .reset   (reset),
            .rst_val (RESET_VALUE[i]),
            .en      (en),
            .load    (load),
            .d       (d[i]),
            .j       (cell_j[i]),
            .k       (cell_k[i]),
            .q       (Q[i])
        );
    end

    assign Q_bar = ~Q;
    assign tc    = en & ~load &
                   (((jk_mode_t'(mode) == MODE_UP) & (&Q)) |
                    ((jk_mode_t'(mode) == MODE_DN) & ~(|Q)));

`ifdef JK_BANK_CHANGE_FLAG_EN
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] changed_q;
    logic [WIDTH-1:0] changed_d;

    // Mirror of the cells' next state so a change is flagged on the same edge it happens.
    always_comb begin
        q_next = Q;
        if (en) begin
            q_next = load ? d : ((cell_j & ~Q) | (~cell_k & Q));
        end
        changed_d = (clr_flags ? '0 : changed_q) | (q_next ^ Q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            changed_q <= '0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign changed = changed_q;
`endif

endmodule

// File: tb/tb_jk_register_bank.sv
// Scoreboard bench for jk_register_bank (WIDTH=4, RESET_VALUE=4'hA).
module tb_jk_register_bank;
    import jk_bank_pkg::*;

    localparam int unsigned W   = 4;
    localparam logic [3:0]  RST = 4'hA;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, load;
    logic [3:0] d, J, K;
    logic [1:0] mode;
    logic [3:0] Q, Q_bar;
    logic       tc;
`ifdef JK_BANK_CHANGE_FLAG_EN
    logic       clr_flags;
    logic [3:0] changed;
`endif

    int         errors = 0;
    int         checks = 0;
    logic [3:0] sb[$];
    logic [3:0] q_model;
    logic       tc_exp;
    logic [3:0] exp_q;

    jk_register_bank #(.WIDTH(W), .RESET_VALUE(RST)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .load      (load),
        .d         (d),
        .mode      (mode),
        .J         (J),
        .K         (K),
`ifdef JK_BANK_CHANGE_FLAG_EN
        .clr_flags (clr_flags),
        .changed   (changed),
`endif
        .Q         (Q),
        .Q_bar     (Q_bar),
        .tc        (tc)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Behavioural reference: arithmetic counting, per-bit JK table.
    function automatic logic [3:0] model_next(input logic [3:0] q, input logic e, input logic l,
                                              input logic [3:0] dd, input logic [1:0] m,
                                              input logic [3:0] jj, input logic [3:0] kk);
        logic [3:0] r;
        r = q;
        if (!e)      return q;
        if (l)       return dd;
        case (m)
            2'b00: for (int i = 0; i < 4; i++) begin
                       if (jj[i] && kk[i]) r[i] = ~q[i];
                       else if (jj[i])     r[i] = 1'b1;
                       else if (kk[i])     r[i] = 1'b0;
                   end
            2'b01: r = dd;
            2'b10: r = q + 4'd1;
            default: r = q - 4'd1;
        endcase
        return r;
    endfunction

    // Apply inputs at the falling edge and record the expected post-edge state.
    task automatic drive(input logic e, input logic l, input logic [3:0] dd, input logic [1:0] m,
                         input logic [3:0] jj, input logic [3:0] kk);
        @(negedge clk);
        en = e; load = l; d = dd; mode = m; J = jj; K = kk;
        tc_exp  = e && !l && ((m == 2'b10 && q_model == 4'hF) || (m == 2'b11 && q_model == 4'h0));
        q_model = model_next(q_model, e, l, dd, m, jj, kk);
        sb.push_back(q_model);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; load = 1'b0; d = '0; mode = MODE_JK; J = '0; K = '0;
`ifdef JK_BANK_CHANGE_FLAG_EN
        clr_flags = 1'b0;
`endif
        #3;
        checks++; if (Q !== RST) begin errors++; $display("FAIL reset_q: got %h want %h", Q, RST); end
        checks++; if (Q_bar !== ~RST) begin errors++; $display("FAIL reset_qbar: got %h want %h", Q_bar, ~RST); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc: got %b want 0", tc); end
        @(negedge clk);
        reset = 1'b0;
        q_model = RST;
    endtask

    task automatic test_jk();
        logic [3:0] rj, rk;
        for (int s = 0; s < 10; s++) begin
            rj = 4'($urandom_range(0, 15));
            rk = 4'($urandom_range(0, 15));
            case (s)
                0: drive(1'b1, 1'b1, 4'b0101, MODE_JK, 4'h0, 4'h0);
                1: drive(1'b1, 1'b0, 4'h0, MODE_JK, 4'b1100, 4'b1010);
                2: drive(1'b1, 1'b0, 4'h9, MODE_D, rj, rk);
                3: drive(1'b1, 1'b0, 4'h3, MODE_JK, 4'hF, 4'hF);
                default: drive(1'b1, 1'b0, 4'($urandom_range(0, 15)), MODE_JK, rj, rk);
            endcase
            #1;
            checks++; if (tc !== tc_exp) begin errors++; $display("FAIL jk_tc[%0d]: got %b want %b", s, tc, tc_exp); end
            tick();
            exp_q = sb.pop_front();
            checks++; if (Q !== exp_q) begin errors++; $display("FAIL jk_q[%0d]: got %h want %h", s, Q, exp_q); end
            checks++; if (Q_bar !== ~exp_q) begin errors++; $display("FAIL jk_qbar[%0d]: got %h want %h", s, Q_bar, ~exp_q); end
        end
    endtask

    task automatic test_count_up();
        for (int s = 0; s < 6; s++) begin
            case (s)
                0: drive(1'b1, 1'b1, 4'hE, MODE_UP, 4'h0, 4'h0);
                1: drive(1'b1, 1'b0, 4'h0, MODE_UP, 4'h5, 4'h3);
                2: drive(1'b1, 1'b0, 4'h0, MODE_UP, 4'h0, 4'h0);
                3: drive(1'b1, 1'b0, 4'h0, MODE_UP, 4'h0, 4'h0);
                4: drive(1'b0, 1'b0, 4'h0, MODE_UP, 4'h0, 4'h0);
                default: drive(1'b0, 1'b1, 4'h7, MODE_UP, 4'h0, 4'h0);
            endcase
            #1;
            checks++; if (tc !== tc_exp) begin errors++; $display("FAIL up_tc[%0d]: got %b want %b", s, tc, tc_exp); end
            tick();
            exp_q = sb.pop_front();
            checks++; if (Q !== exp_q) begin errors++; $display("FAIL up_q[%0d]: got %h want %h", s, Q, exp_q); end
        end
    endtask

    task automatic test_count_down();
        for (int s = 0; s < 6; s++) begin
            case (s)
                0: drive(1'b1, 1'b1, 4'h1, MODE_DN, 4'h0, 4'h0);
                1: drive(1'b1, 1'b0, 4'h0, MODE_DN, 4'h0, 4'h0);
                2: drive(1'b1, 1'b0, 4'h0, MODE_DN, 4'h0, 4'h0);
                3: drive(1'b1, 1'b0, 4'h0, MODE_DN, 4'h0, 4'h0);
                4: drive(1'b1, 1'b1, 4'h6, MODE_DN, 4'h0, 4'h0);
                default: drive(1'b1, 1'b0, 4'h0, MODE_DN, 4'h0, 4'h0);
            endcase
            #1;
            checks++; if (tc !== tc_exp) begin errors++; $display("FAIL dn_tc[%0d]: got %b want %b", s, tc, tc_exp); end
            tick();
            exp_q = sb.pop_front();
            checks++; if (Q !== exp_q) begin errors++; $display("FAIL dn_q[%0d]: got %h want %h", s, Q, exp_q); end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 4'h7, MODE_UP, 4'h0, 4'h0);
        tick();
        exp_q = sb.pop_front();
        checks++; if (Q !== exp_q) begin errors++; $display("FAIL mid_load: got %h want %h", Q, exp_q); end
        drive(1'b1, 1'b0, 4'h0, MODE_UP, 4'h0, 4'h0);
        #2 reset = 1'b1;
        #1;
        checks++; if (Q !== RST) begin errors++; $display("FAIL mid_rst_q: got %h want %h", Q, RST); end
        checks++; if (Q_bar !== ~RST) begin errors++; $display("FAIL mid_rst_qbar: got %h want %h", Q_bar, ~RST); end
        #1 reset = 1'b0;
        void'(sb.pop_front());
        q_model = model_next(RST, en, load, d, mode, J, K);
        sb.push_back(q_model);
        tick();
        exp_q = sb.pop_front();
        checks++; if (Q !== exp_q) begin errors++; $display("FAIL mid_resume: got %h want %h", Q, exp_q); end
    endtask

`ifdef JK_BANK_CHANGE_FLAG_EN
    task automatic test_change_flags();
        logic [3:0] chg_model;
        logic [3:0] old_q;
        @(negedge clk);
        reset = 1'b1;
        #1 reset = 1'b0;
        q_model = RST;
        chg_model = '0;
        checks++; if (changed !== 4'h0) begin errors++; $display("FAIL chg_reset: got %h want 0", changed); end
        for (int s = 0; s < 6; s++) begin
            old_q = q_model;
            case (s)
                0: begin clr_flags = 1'b0; drive(1'b1, 1'b1, 4'h0, MODE_UP, 4'h0, 4'h0); end
                1: begin clr_flags = 1'b1; drive(1'b0, 1'b0, 4'h0, MODE_UP, 4'h0, 4'h0); end
                2: begin clr_flags = 1'b0; drive(1'b1, 1'b0, 4'h0, MODE_UP, 4'h0, 4'h0); end
                3: begin clr_flags = 1'b1; drive(1'b1, 1'b0, 4'h0, MODE_UP, 4'h0, 4'h0); end
                4: begin clr_flags = 1'b0; drive(1'b0, 1'b0, 4'h0, MODE_UP, 4'h0, 4'h0); end
                default: begin clr_flags = 1'b1; drive(1'b0, 1'b0, 4'h0, MODE_UP, 4'h0, 4'h0); end
            endcase
            chg_model = (clr_flags ? 4'h0 : chg_model) | (old_q ^ q_model);
            tick();
            exp_q = sb.pop_front();
            checks++; if (Q !== exp_q) begin errors++; $display("FAIL chg_q[%0d]: got %h want %h", s, Q, exp_q); end
            checks++; if (changed !== chg_model) begin errors++; $display("FAIL chg_flags[%0d]: got %h want %h", s, changed, chg_model); end
        end
        clr_flags = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_jk();
        test_count_up();
        test_count_down();
        test_reset_mid();
`ifdef JK_BANK_CHANGE_FLAG_EN
        test_change_flags();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
